seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width; the design SHALL support any even WIDTH >= 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on a rising clk edge only while idle.
REQ-005 inA, inB  input  WIDTH  operands, captured when start is accepted.
REQ-006 inC  input  1  carry-in, captured when start is accepted.
REQ-007 opc  input  3  operation code, captured when start is accepted.
REQ-008 busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 done  output  1  one-cycle pulse; the new outW, zer and neg are valid.
REQ-010 outW  output  WIDTH  registered result, held until the next done.
REQ-011 zer, neg  output  1  registered flags: outW == 0, and outW[WIDTH-1].

Function
REQ-012 Opcodes SHALL be: 000 ~A+1; 001 A+1; 010 A+B+C; 011 A+(B>>1); 100 A&B; 101 A|B; 110 {A[WIDTH/2-1:0], B[WIDTH/2-1:0]}; 111 A*B, low WIDTH bits.
REQ-013 All arithmetic SHALL be unsigned modulo 2^WIDTH; the carry-in affects only opc 010.
REQ-014 The FSM states SHALL be IDLE and MUL. IDLE with start and opc!=111 SHALL return to IDLE. IDLE with start and opc==111 SHALL go to MUL. MUL SHALL return to IDLE after WIDTH cycles.
REQ-015 Single-cycle ops: start accepted at edge k -> outW/zer/neg updated and done=1 from edge k to edge k+1; busy stays 0.
REQ-016 Multiply: start accepted at edge k -> busy=1 from edge k to edge k+WIDTH. The multiply SHALL be shift-and-add, one multiplier bit per cycle. At edge k+WIDTH the result SHALL load, busy SHALL fall and done SHALL pulse for one cycle.
REQ-017 start while busy SHALL be ignored: no capture, no effect on the operation in flight.
REQ-018 start is legal in the cycle done is high and SHALL be accepted (back-to-back operation).
REQ-019 outW, zer and neg SHALL change only at a done edge or at reset. done SHALL never be high for two consecutive cycles unless two single-cycle starts are back-to-back.
REQ-020 Operand inputs changing while busy SHALL NOT affect the result.

Reset
REQ-021 rst high SHALL immediately force: state IDLE, busy=0, done=0, outW=0, zer=0, neg=0, and all internal accumulators to 0.
REQ-022 Reset during MUL SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-023 With macro SEQ_ALU_COUT_EN defined, output port cout (1 bit, registered, updated with done, reset 0) SHALL exist.
- opc 000/001/010/011: carry-out of the WIDTH-bit addition.
- opc 111: 1 if product bits [2*WIDTH-1:WIDTH] are nonzero.
- opc 100/101/110: 0.
REQ-024 Without SEQ_ALU_COUT_EN, the cout port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, SEQ_ALU_COUT_EN defined)
REQ-025 opc=010, A=FFFF, B=0000, C=1, start -> next cycle: outW=0000, zer=1, neg=0, cout=1, done=1 for one cycle, busy=0.
REQ-026 opc=000, A=0005 -> outW=FFFB, neg=1, zer=0, cout=0. Then opc=110, A=12AB, B=34CD -> outW=ABCD, neg=1, cout=0.
REQ-027 opc=111, A=012C (300), B=00C8 (200) -> busy high 16 cycles, then done: outW=EA60, neg=1, cout=0. A=0100, B=0100 -> outW=0000, zer=1, cout=1.
REQ-028 During a multiply, apply start with opc=100 on cycle 3 -> ignored; the multiply result is unchanged, and only one done pulse occurs at cycle 16.
REQ-029 rst pulsed on cycle 5 of a multiply -> busy, done, outW, zer, neg and cout all 0 immediately, no done pulse. A following opc=001, A=0007 -> outW=0008.
REQ-030 Back-to-back: start with opc=101 in the done cycle of an opc=010 operation -> two consecutive done pulses, each with its correct result.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/logic ops plus a WIDTH-cycle shift-and-add multiply.
// Optional carry-out port enabled with macro SEQ_ALU_COUT_EN.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic [2:0]       opc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg
`ifdef SEQ_ALU_COUT_EN
  ,
  output logic             cout
`endif
);

  // Carry bit and upper product half only exist when the carry-out is exported.
`ifdef SEQ_ALU_COUT_EN
  localparam int RW = WIDTH + 1;
  localparam int AW = 2 * WIDTH;
`else
  localparam int RW = WIDTH;
  localparam int AW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;

  logic [RW-1:0]    sum;
  logic [WIDTH-1:0] sc_res;
  logic [AW-1:0]    prod_next;
  logic [WIDTH-1:0] mul_res;

  // Single-cycle result; logic ops are zero-extended so their carry bit reads as 0.
  always_comb begin
    sum = '0;
    case (opc)
      3'b000:  sum = RW'(~inA) + RW'(1'b1);
      3'b001:  sum = RW'(inA) + RW'(1'b1);
      3'b010:  sum = RW'(inA) + RW'(inB) + RW'(inC);
      3'b011:  sum = RW'(inA) + RW'(inB >> 1'b1);
      3'b100:  sum = RW'(inA & inB);
      3'b101:  sum = RW'(inA | inB);
      3'b110:  sum = RW'({inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]});
      default: sum = '0;
    endcase
  end

  assign sc_res    = sum[WIDTH-1:0];
  assign prod_next = acc + (mplier[0] ? mcand : '0);
  assign mul_res   = prod_next[WIDTH-1:0];

  // Control FSM, multiply datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      outW   <= '0;
      zer    <= 1'b0;
      neg    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`ifdef SEQ_ALU_COUT_EN
      cout   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && (opc == 3'b111)) begin
            state  <= MUL;
            busy   <= 1'b1;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= AW'(inA);
            mplier <= inB;
          end else if (start) begin
            done <= 1'b1;
            outW <= sc_res;
            zer  <= (sc_res == '0);
            neg  <= sc_res[WIDTH-1];
`ifdef SEQ_ALU_COUT_EN
            cout <= sum[RW-1];
`endif
          end else begin
            done <= 1'b0;
          end
        end
        MUL: begin
          acc    <= prod_next;
          mcand  <= mcand << 1'b1;
          mplier <= mplier >> 1'b1;
          cnt    <= cnt + CW'(1'b1);
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            outW  <= mul_res;
            zer   <= (mul_res == '0);
            neg   <= mul_res[WIDTH-1];
`ifdef SEQ_ALU_COUT_EN
            cout  <= |prod_next[AW-1:WIDTH];
`endif
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16); checks cout only when SEQ_ALU_COUT_EN is defined.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         inC;
  logic [2:0]   opc;
  logic         busy;
  logic         done;
  logic [W-1:0] outW;
  logic         zer;
  logic         neg;
  logic         cout_obs;

`ifdef SEQ_ALU_COUT_EN
  logic cout;
  assign cout_obs = cout;
`else
  assign cout_obs = 1'b0;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB), .inC(inC), .opc(opc),
    .busy(busy), .done(done), .outW(outW), .zer(zer), .neg(neg)
`ifdef SEQ_ALU_COUT_EN
    , .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    logic         z;
    logic         n;
    logic         c;
    string        name;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           hold_errs = 0;
  logic [W-1:0] hold_w = '0;
  logic         hold_z = 1'b0;
  logic         hold_n = 1'b0;
  logic         hold_c = 1'b0;

  // Monitor: every done pulse pops one expectation; between pulses outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (!rst) begin
      if (done) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got done with outW=%h, required no done", outW);
        end else begin
          e = q.pop_front();
          ok = (outW === e.w) && (zer === e.z) && (neg === e.n);
`ifdef SEQ_ALU_COUT_EN
          ok = ok && (cout_obs === e.c);
`endif
          if (!ok) begin
            miscompares++;
            $display("FAIL %s: got outW=%h zer=%b neg=%b cout=%b, required outW=%h zer=%b neg=%b cout=%b",
                     e.name, outW, zer, neg, cout_obs, e.w, e.z, e.n, e.c);
          end
          hold_w = e.w;
          hold_z = e.z;
          hold_n = e.n;
          hold_c = e.c;
        end
      end else begin
        if ((outW !== hold_w) || (zer !== hold_z) || (neg !== hold_n)) hold_errs++;
`ifdef SEQ_ALU_COUT_EN
        if (cout_obs !== hold_c) hold_errs++;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Drive one start at a negedge and push its hand-computed expectation; returns one cycle later.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] ew, input logic ez, input logic en, input logic ec,
                       input string name);
    exp_t e;
    e.w = ew; e.z = ez; e.n = en; e.c = ec; e.name = name;
    opc = op; inA = a; inB = b; inC = c; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    start = 1'b0;
    while ((q.size() != 0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
    @(negedge clk);
  endtask

  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ew, input logic ez, input logic en, input logic ec,
                         input string name, input bit inject);
    int busy_cycles = 0;
    issue(3'b111, a, b, 1'b0, ew, ez, en, ec, name);
    start = 1'b0;
    for (int i = 0; (i < 40) && busy; i++) begin
      busy_cycles++;
      if (inject && (i == 2)) begin
        opc = 3'b100; inA = 16'hFFFF; inB = 16'hFFFF; inC = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
        if (inject) begin
          inA = 16'h5A5A ^ 16'(i);
          inB = 16'hA5A5 ^ 16'(i);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_busy_cycles"}, busy_cycles, 16);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; opc = 3'b000; inA = '0; inB = '0; inC = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outW", outW, 0);
    check("rst_zer", zer, 0);
    check("rst_neg", neg, 0);
`ifdef SEQ_ALU_COUT_EN
    check("rst_cout", cout_obs, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    issue(3'b010, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "add_carry_wrap");
    check("sc_busy_low", busy, 0);
    start = 1'b0;
    @(negedge clk);
    issue(3'b000, 16'h0005, 16'h0000, 1'b0, 16'hFFFB, 1'b0, 1'b1, 1'b0, "neg_a");
    issue(3'b110, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0, "pack_halves");
    issue(3'b011, 16'h0001, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, "add_half_b");
    issue(3'b100, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b1, 1'b0, "and_ab");
    issue(3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "inc_wrap");
    issue(3'b000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "neg_zero");
    wait_drain("drain_single");

    issue(3'b010, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, "b2b_add");
    issue(3'b101, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, "b2b_or");
    wait_drain("drain_b2b");

    mul_run(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, "mul_ignore_start", 1'b1);
    mul_run(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, "mul_overflow", 1'b0);
    mul_run(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, "mul_max", 1'b0);
    mul_run(16'h012C, 16'h00C8, 16'hEA60, 1'b0, 1'b1, 1'b0, "mul_300x200", 1'b0);
    wait_drain("drain_mul");

    // Abort a multiply with reset in its fifth cycle.
    opc = 3'b111; inA = 16'h0123; inB = 16'h0456; inC = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    hold_w = '0; hold_z = 1'b0; hold_n = 1'b0; hold_c = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outW", outW, 0);
    check("abort_neg", neg, 0);
    check("abort_zer", zer, 0);
`ifdef SEQ_ALU_COUT_EN
    check("abort_cout", cout_obs, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(3'b001, 16'h0007, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, "inc_after_reset");
    wait_drain("drain_reset");

    check("output_hold", hold_errs, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
